// File: rtl/hazard_ctrl.sv
// ============================================================================
// hazard_ctrl
// ----------------------------------------------------------------------------
// Scoreboard-based hazard controller for the RV32I pipeline. It sits beside
// the decode stage and counts in-flight register writes that have issued past
// decode. It stalls fetch/decode when the decoded instruction reads a register
// with a pending write, or would push a destination past MAX_INFLIGHT
// outstanding writes. It also holds refill bubbles for FLUSH_CYCLES cycles
// after a pipeline flush. Writeback reports retirement on the register-file
// write port.
//
// Parameters
//   MAX_INFLIGHT  maximum outstanding writes per register (1..3)
//   FLUSH_CYCLES  bubble cycles held after FLUSH (1..15)
//
// Ports
//   CLK, RST            clock, synchronous active-high reset
//   D_VALID             decode holds a valid instruction
//   D_REG_D/S1/S2       rd, rs1, rs2 from decode
//   D_USE_S1/S2         instruction reads rs1 / rs2
//   D_WRITE_D           instruction writes rd
//   E_READY             execute accepts an instruction this cycle
//   W_VALID, W_REG_D    writeback register-file write and its destination
//   FLUSH               redirect; kills everything past decode
//   STALL               hold fetch/decode (combinational)
//   ISSUE               decode instruction advances (combinational)
//   BUSY_MASK           bit n set while register n has a pending write
//   ERR                 sticky: retire to a register with no pending write
//   STALL_CNT           saturating stall-cycle counter
//
// Build option
//   HAZARD_STALL_STATS_EN  when defined, STALL_CNT counts stall cycles;
//                          otherwise the counter is not built and reads 0.
// ============================================================================
module hazard_ctrl #(
    parameter int MAX_INFLIGHT = 3,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        D_VALID,
    input  logic [4:0]  D_REG_D,
    input  logic [4:0]  D_REG_S1,
    input  logic [4:0]  D_REG_S2,
    input  logic        D_USE_S1,
    input  logic        D_USE_S2,
    input  logic        D_WRITE_D,
    input  logic        E_READY,
    input  logic        W_VALID,
    input  logic [4:0]  W_REG_D,
    input  logic        FLUSH,
    output logic        STALL,
    output logic        ISSUE,
    output logic [31:0] BUSY_MASK,
    output logic        ERR,
    output logic [31:0] STALL_CNT
);

    localparam logic [1:0] MAX_CNT     = 2'(MAX_INFLIGHT);
    localparam logic [3:0] REFILL_LOAD = 4'(FLUSH_CYCLES - 1);

    typedef enum logic [1:0] {
        RUN,
        HOLD,
        REFILL
    } state_t;

    state_t           state, state_next;
    logic [3:0]       refill_cnt, refill_next;
    // Entry 0 exists only so register indices map directly; it stays zero.
    logic [31:0][1:0] pend_cnt, pend_next;
    logic [31:0]      inc_vec, dec_vec;
    logic             err_q, err_next;
    logic             hz_s1, hz_s2, hz_d, hazard;
    logic             orphan_retire;

    // Hazard detection from registered counters and current decode inputs.
    // No bypass: a retire only clears the hazard after its edge has updated
    // the counters, matching the register-file write timing.
    always_comb begin
        hz_s1  = D_USE_S1  & (D_REG_S1 != 5'd0) & (pend_cnt[D_REG_S1] != 2'd0);
        hz_s2  = D_USE_S2  & (D_REG_S2 != 5'd0) & (pend_cnt[D_REG_S2] != 2'd0);
        hz_d   = D_WRITE_D & (D_REG_D  != 5'd0) & (pend_cnt[D_REG_D]  == MAX_CNT);
        hazard = D_VALID & (hz_s1 | hz_s2 | hz_d | ~E_READY);
    end

    // Control FSM next-state and STALL. RUN and HOLD stall identically on the
    // hazard; REFILL forces a stall while the refill counter runs down. A
    // FLUSH seen in REFILL restarts the bubble window.
    always_comb begin
        state_next  = state;
        refill_next = refill_cnt;
        STALL       = hazard;
        case (state)
            RUN: begin
                if (FLUSH) begin
                    state_next  = REFILL;
                    refill_next = REFILL_LOAD;
                end else if (hazard) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (FLUSH) begin
                    state_next  = REFILL;
                    refill_next = REFILL_LOAD;
                end else if (!hazard) begin
                    state_next = RUN;
                end
            end
            REFILL: begin
                STALL = 1'b1;
                if (FLUSH) begin
                    refill_next = REFILL_LOAD;
                end else if (refill_cnt == 4'd0) begin
                    state_next = RUN;
                end else begin
                    refill_next = refill_cnt - 4'd1;
                end
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

    assign ISSUE = D_VALID & ~STALL & ~FLUSH;

    // One-hot increment/decrement requests. A retire only decrements when a
    // write is actually pending, so a stray retire never underflows.
    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        if (ISSUE && D_WRITE_D && (D_REG_D != 5'd0)) begin
            inc_vec[D_REG_D] = 1'b1;
        end
        if (W_VALID && (W_REG_D != 5'd0) && (pend_cnt[W_REG_D] != 2'd0)) begin
            dec_vec[W_REG_D] = 1'b1;
        end
    end

    assign orphan_retire = W_VALID & ~FLUSH & (W_REG_D != 5'd0)
                         & (pend_cnt[W_REG_D] == 2'd0);

    // Counter update. FLUSH wipes every count because killed instructions
    // will never retire; a retire in the flush cycle is ignored. Simultaneous
    // issue and retire on one register cancel out.
    always_comb begin
        pend_next = pend_cnt;
        err_next  = err_q | orphan_retire;
        if (FLUSH) begin
            pend_next = '0;
        end else begin
            for (int r = 1; r < 32; r++) begin
                case ({inc_vec[r], dec_vec[r]})
                    2'b10:   pend_next[r] = pend_cnt[r] + 2'd1;
                    2'b01:   pend_next[r] = pend_cnt[r] - 2'd1;
                    default: pend_next[r] = pend_cnt[r];
                endcase
            end
        end
        pend_next[0] = 2'd0;
    end

    // State registers; reset wins over flush, issue and retire.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= RUN;
            refill_cnt <= 4'd0;
            pend_cnt   <= '0;
            err_q      <= 1'b0;
        end else begin
            state      <= state_next;
            refill_cnt <= refill_next;
            pend_cnt   <= pend_next;
            err_q      <= err_next;
        end
    end

    // Busy mask straight from the registered counters.
    always_comb begin
        BUSY_MASK = '0;
        for (int r = 1; r < 32; r++) begin
            BUSY_MASK[r] = (pend_cnt[r] != 2'd0);
        end
    end

    assign ERR = err_q;

`ifdef HAZARD_STALL_STATS_EN
    logic [31:0] stall_cnt_q;

    // Saturating count of cycles with STALL high; only RST clears it.
    always_ff @(posedge CLK) begin
        if (RST) begin
            stall_cnt_q <= '0;
        end else if (STALL && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign STALL_CNT = stall_cnt_q;
`else
    assign STALL_CNT = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// ============================================================================
// tb_hazard_ctrl
// ----------------------------------------------------------------------------
// Directed testbench for hazard_ctrl. A behavioural scoreboard (per-register
// pending-write counts, remaining refill bubbles, sticky error, stall count)
// predicts STALL, ISSUE, BUSY_MASK, ERR and STALL_CNT every cycle. Literal
// checks at key points of the directed sequence pin the scoreboard itself.
// ============================================================================
module tb_hazard_ctrl;

    localparam int MAX_INF = 3;
    localparam int FL_CYC  = 2;

    logic        CLK;
    logic        RST;
    logic        D_VALID;
    logic [4:0]  D_REG_D, D_REG_S1, D_REG_S2;
    logic        D_USE_S1, D_USE_S2, D_WRITE_D;
    logic        E_READY;
    logic        W_VALID;
    logic [4:0]  W_REG_D;
    logic        FLUSH;
    logic        STALL, ISSUE, ERR;
    logic [31:0] BUSY_MASK, STALL_CNT;

    int          n_vec  = 0;
    int          n_err  = 0;
    bit          chk_en = 0;
    bit          rst_req;

    int          pend [32];
    int          refill_left;
    bit          m_err;
    logic [31:0] m_scnt;

    hazard_ctrl #(
        .MAX_INFLIGHT (MAX_INF),
        .FLUSH_CYCLES (FL_CYC)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .D_VALID   (D_VALID),
        .D_REG_D   (D_REG_D),
        .D_REG_S1  (D_REG_S1),
        .D_REG_S2  (D_REG_S2),
        .D_USE_S1  (D_USE_S1),
        .D_USE_S2  (D_USE_S2),
        .D_WRITE_D (D_WRITE_D),
        .E_READY   (E_READY),
        .W_VALID   (W_VALID),
        .W_REG_D   (W_REG_D),
        .FLUSH     (FLUSH),
        .STALL     (STALL),
        .ISSUE     (ISSUE),
        .BUSY_MASK (BUSY_MASK),
        .ERR       (ERR),
        .STALL_CNT (STALL_CNT)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check_output(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s at %0t: got 0x%08h, expected 0x%08h",
                     name, $time, act, exp);
        end
    endtask

    // Drive one cycle of inputs just after the rising edge, return at the
    // following falling edge where outputs are sampled.
    task automatic apply_stimulus(input logic dv, input logic [4:0] rd,
                                  input logic [4:0] rs1, input logic u1,
                                  input logic [4:0] rs2, input logic u2,
                                  input logic wd, input logic er,
                                  input logic wv, input logic [4:0] wr,
                                  input logic fl);
        @(posedge CLK);
        #1;
        RST       = rst_req;
        D_VALID   = dv;
        D_REG_D   = rd;
        D_REG_S1  = rs1;
        D_USE_S1  = u1;
        D_REG_S2  = rs2;
        D_USE_S2  = u2;
        D_WRITE_D = wd;
        E_READY   = er;
        W_VALID   = wv;
        W_REG_D   = wr;
        FLUSH     = fl;
        @(negedge CLK);
    endtask

    task automatic idle();
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    endtask

    task automatic write_rd(input logic [4:0] rd);
        apply_stimulus(1, rd, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    endtask

    task automatic retire(input logic [4:0] wr);
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 1, 1, wr, 0);
    endtask

    // Scoreboard: compare against the prediction for this cycle, then
    // advance the prediction using the inputs the next edge will see.
    always @(negedge CLK) begin
        bit          hz, e_stall, e_issue;
        logic [31:0] e_busy;
        hz = D_VALID && ((D_USE_S1 && D_REG_S1 != 0 && pend[D_REG_S1] != 0) ||
                         (D_USE_S2 && D_REG_S2 != 0 && pend[D_REG_S2] != 0) ||
                         (D_WRITE_D && D_REG_D != 0 && pend[D_REG_D] >= MAX_INF) ||
                         !E_READY);
        e_stall = (refill_left > 0) || hz;
        e_issue = D_VALID && !e_stall && !FLUSH;
        e_busy  = '0;
        for (int r = 1; r < 32; r++) e_busy[r] = (pend[r] != 0);

        if (chk_en) begin
            check_output("model_stall", STALL, e_stall);
            check_output("model_issue", ISSUE, e_issue);
            check_output("model_busy",  BUSY_MASK, e_busy);
            check_output("model_err",   ERR, m_err);
            check_output("model_stall_cnt", STALL_CNT, m_scnt);
        end

        if (RST) begin
            for (int r = 0; r < 32; r++) pend[r] = 0;
            refill_left = 0;
            m_err       = 0;
            m_scnt      = '0;
        end else begin
`ifdef HAZARD_STALL_STATS_EN
            if (e_stall && m_scnt != 32'hFFFF_FFFF) m_scnt = m_scnt + 1;
`endif
            if (FLUSH) begin
                for (int r = 0; r < 32; r++) pend[r] = 0;
                refill_left = FL_CYC;
            end else begin
                if (refill_left > 0) refill_left--;
                if (W_VALID && W_REG_D != 0) begin
                    if (pend[W_REG_D] == 0) m_err = 1;
                    else pend[W_REG_D]--;
                end
                if (e_issue && D_WRITE_D && D_REG_D != 0) pend[D_REG_D]++;
            end
        end
    end

    initial begin
        logic [31:0] exp_scnt;
        for (int r = 0; r < 32; r++) pend[r] = 0;
        refill_left = 0;
        m_err       = 0;
        m_scnt      = '0;
        rst_req   = 1;
        RST       = 1;
        D_VALID   = 0;
        D_REG_D   = 0;
        D_REG_S1  = 0;
        D_REG_S2  = 0;
        D_USE_S1  = 0;
        D_USE_S2  = 0;
        D_WRITE_D = 0;
        E_READY   = 1;
        W_VALID   = 0;
        W_REG_D   = 0;
        FLUSH     = 0;

        idle();
        idle();
        rst_req = 0;
        chk_en  = 1;
        idle();
        check_output("reset_stall", STALL, 0);
        check_output("reset_issue", ISSUE, 0);
        check_output("reset_busy", BUSY_MASK, 0);
        check_output("reset_err", ERR, 0);
        check_output("reset_stall_cnt", STALL_CNT, 0);

        // addi x5 then add x6,x5,x1: stall until the cycle after x5 retires
        write_rd(5);
        check_output("addi_issue", ISSUE, 1);
        idle();
        check_output("addi_busy", BUSY_MASK, 32'h0000_0020);
        apply_stimulus(1, 6, 5, 1, 1, 1, 1, 1, 0, 0, 0);
        check_output("raw_stall", STALL, 1);
        apply_stimulus(1, 6, 5, 1, 1, 1, 1, 1, 1, 5, 0);
        check_output("raw_no_bypass", STALL, 1);
        apply_stimulus(1, 6, 5, 1, 1, 1, 1, 1, 0, 0, 0);
        check_output("raw_release", ISSUE, 1);
        check_output("raw_busy_clear", BUSY_MASK, 0);
        idle();
        check_output("add_busy", BUSY_MASK, 32'h0000_0040);
        retire(6);
        idle();

        // x7 write-count limit, and issue+retire on one register cancelling
        write_rd(7);
        check_output("x7_w1", ISSUE, 1);
        write_rd(7);
        write_rd(7);
        write_rd(7);
        check_output("x7_limit", STALL, 1);
        apply_stimulus(1, 7, 0, 0, 0, 0, 1, 1, 1, 7, 0);
        check_output("x7_limit_retire", STALL, 1);
        write_rd(7);
        check_output("x7_w4", ISSUE, 1);
        retire(7);
        apply_stimulus(1, 7, 0, 0, 0, 0, 1, 1, 1, 7, 0);
        check_output("x7_issue_retire", ISSUE, 1);
        write_rd(7);
        check_output("x7_w6", ISSUE, 1);
        write_rd(7);
        check_output("x7_limit2", STALL, 1);
        retire(7);
        retire(7);
        retire(7);
        idle();
        check_output("x7_drained", BUSY_MASK, 0);

        // x0 source and destination never tracked
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(1, 0, 0, 1, 0, 1, 1, 1, 0, 0, 0);
            check_output("x0_no_stall", STALL, 0);
        end
        idle();
        check_output("x0_busy", BUSY_MASK, 0);

        // FLUSH with x3,x4 pending and a same-cycle retire of x3
        write_rd(3);
        write_rd(4);
        apply_stimulus(1, 10, 0, 0, 0, 0, 1, 1, 1, 3, 1);
        check_output("flush_cycle_stall", STALL, 0);
        check_output("flush_cycle_issue", ISSUE, 0);
        write_rd(10);
        check_output("refill1_stall", STALL, 1);
        check_output("flush_busy", BUSY_MASK, 0);
        check_output("flush_err", ERR, 0);
        write_rd(10);
        check_output("refill2_stall", STALL, 1);
        write_rd(10);
        check_output("refill_done_issue", ISSUE, 1);
        retire(10);

        // FLUSH repeated during refill restarts the bubble window
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1);
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1);
        write_rd(14);
        write_rd(14);
        check_output("reflush_stall", STALL, 1);
        write_rd(14);
        check_output("reflush_issue", ISSUE, 1);
        retire(14);

        // Orphan retires: x0 ignored, x9 sets sticky ERR
        retire(0);
        idle();
        check_output("x0_retire_err", ERR, 0);
        retire(9);
        idle();
        check_output("orphan_err", ERR, 1);
        write_rd(11);
        retire(11);
        idle();
        check_output("err_sticky", ERR, 1);

        // RST together with FLUSH and pending writes
        write_rd(12);
        rst_req = 1;
        apply_stimulus(1, 12, 0, 0, 0, 0, 1, 1, 1, 9, 1);
        rst_req = 0;
        write_rd(13);
        check_output("rst_over_flush", STALL, 0);
        check_output("rst_err_clear", ERR, 0);
        check_output("rst_busy_clear", BUSY_MASK, 0);
        retire(13);

        // Stall statistics: 10 cycles of execute back-pressure
        rst_req = 1;
        idle();
        rst_req = 0;
        for (int i = 0; i < 10; i++) begin
            apply_stimulus(1, 15, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        end
        idle();
`ifdef HAZARD_STALL_STATS_EN
        exp_scnt = 32'd10;
`else
        exp_scnt = 32'd0;
`endif
        check_output("stall_cnt", STALL_CNT, exp_scnt);
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
